// File: rtl/blake2b_msg_sched_pkg.sv
// BLAKE2b message scheduler shared definitions: bus widths, FSM encoding
// and the 10-row sigma permutation table (rows 10/11 reuse rows 0/1).
package blake2b_msg_sched_pkg;

  localparam int BLAKE2B_ROUNDS = 12;

  typedef logic [3:0] round_t;   // round counter r
  typedef logic [2:0] gidx_t;    // G step g
  typedef logic [3:0] sidx_t;    // sigma column index
  typedef logic [3:0] midx_t;    // message word index

  typedef enum logic {ST_LOAD, ST_SCHED} state_e;

  // One sigma row packed as 16 nibbles, column 0 in the top nibble.
  function automatic logic [63:0] sigma_row(input round_t r);
    case (r)
      4'd0, 4'd10: sigma_row = 64'h0123456789ABCDEF;
      4'd1, 4'd11: sigma_row = 64'hEA489FD61C02B753;
      4'd2:        sigma_row = 64'hB8C052FDAE367194;
      4'd3:        sigma_row = 64'h7931DCBE265A40F8;
      4'd4:        sigma_row = 64'h905724AFE1BC683D;
      4'd5:        sigma_row = 64'h2C6A0B834D75FE19;
      4'd6:        sigma_row = 64'hC51FED4A0763928B;
      4'd7:        sigma_row = 64'hDB7EC13950F4862A;
      4'd8:        sigma_row = 64'h6FE9B308C2D714A5;
      4'd9:        sigma_row = 64'hA2847615FB9E3CD0;
      default:     sigma_row = 64'h0123456789ABCDEF;
    endcase
  endfunction

endpackage

// File: rtl/blake2b_msg_sched_sigma.sv
// Sigma permutation lookup: (row, column) -> message word index.
module blake2b_sigma
  import blake2b_msg_sched_pkg::*;
(
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output logic [3:0] idx_o
);

  logic [63:0] row_w;

  // Column c sits at nibble (15-c); ~c is 15-c for a 4-bit column.
  always_comb begin
    row_w = sigma_row(row_i);
    idx_o = row_w[{~col_i, 2'b00} +: 4];
  end

endmodule

// File: rtl/blake2b_msg_sched.sv
// BLAKE2b message-word scheduler: buffers a 16-word block, then emits
// m[sigma[r][2g]], m[sigma[r][2g+1]] per (r,g) over valid/ready.
// Optional feature macro: BLAKE2B_MSG_PRELOAD_EN (double-buffered block
// store so the next block streams in while the current one schedules).
module blake2b_msg_sched
  import blake2b_msg_sched_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int ROUNDS = BLAKE2B_ROUNDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  input  logic [WORD_W-1:0] msg_word_i,
  output logic              g_valid_o,
  input  logic              g_ready_i,
  output logic [WORD_W-1:0] g_mx_o,
  output logic [WORD_W-1:0] g_my_o,
  output logic [3:0]        g_round_o,
  output logic [2:0]        g_index_o,
  output logic              g_last_o,
  output logic              blk_done_o
);

`ifdef BLAKE2B_MSG_PRELOAD_EN
  localparam int AW = 5;
`else
  localparam int AW = 4;
`endif
  localparam round_t LAST_R = 4'(ROUNDS - 1);

  logic [WORD_W-1:0] buf_q [0:(1<<AW)-1];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  round_t            r_q, r_d;
  gidx_t             g_q, g_d;
  logic              vld_q, vld_d, last_q, last_d, done_q, done_d;
  logic [WORD_W-1:0] mx_q, mx_d, my_q, my_d;
  logic              beat, acc, ld_pair;
  midx_t             sx, sy;
  logic [AW-1:0]     rd_x, rd_y, wr_addr;

`ifdef BLAKE2B_MSG_PRELOAD_EN
  logic bank_q, bank_d, full_q, full_d;
  // Shadow bank keeps filling during SCHED until it holds a whole block.
  assign msg_ready_o = (state_q == ST_LOAD) || !full_q;
  assign wr_addr     = {(state_q == ST_SCHED) ? ~bank_q : bank_q, cnt_q};
  assign rd_x        = {bank_d, sx};
  assign rd_y        = {bank_d, sy};
`else
  assign msg_ready_o = (state_q == ST_LOAD);
  assign wr_addr     = cnt_q;
  assign rd_x        = sx;
  assign rd_y        = sy;
`endif

  assign beat = msg_valid_i && msg_ready_o;
  assign acc  = vld_q && g_ready_i;

  // Lookups are driven by the next (r,g) so the pair registers load in step.
  blake2b_sigma u_sig_x (.row_i(r_d), .col_i({g_d, 1'b0}), .idx_o(sx));
  blake2b_sigma u_sig_y (.row_i(r_d), .col_i({g_d, 1'b1}), .idx_o(sy));

  // FSM and r/g counter next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    g_d     = g_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    ld_pair = 1'b0;
`ifdef BLAKE2B_MSG_PRELOAD_EN
    bank_d  = bank_q;
    full_d  = full_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (beat) begin
          cnt_d = cnt_q + 4'd1;   // wraps to 0 on the 16th beat
          if (cnt_q == 4'd15) begin
            state_d = ST_SCHED;
            r_d     = '0;
            g_d     = '0;
            vld_d   = 1'b1;
            ld_pair = 1'b1;
          end
        end
      end
      ST_SCHED: begin
`ifdef BLAKE2B_MSG_PRELOAD_EN
        if (beat) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) full_d = 1'b1;
        end
`endif
        if (acc) begin
          if (last_q) begin
            done_d = 1'b1;
            r_d    = '0;
            g_d    = '0;
`ifdef BLAKE2B_MSG_PRELOAD_EN
            // Swap even when the shadow is partial so its words carry into LOAD.
            bank_d = ~bank_q;
            if (full_d) begin
              full_d  = 1'b0;
              vld_d   = 1'b1;
              ld_pair = 1'b1;
            end else begin
              state_d = ST_LOAD;
              vld_d   = 1'b0;
            end
`else
            state_d = ST_LOAD;
            vld_d   = 1'b0;
            cnt_d   = '0;
`endif
          end else begin
            g_d     = g_q + 3'd1;
            if (g_q == 3'd7) r_d = r_q + 4'd1;
            ld_pair = 1'b1;
          end
        end
      end
      default: ;
    endcase
    last_d = vld_d && (r_d == LAST_R) && (g_d == 3'd7);
  end

  // Operand pair capture from the message store.
  always_comb begin
    mx_d = mx_q;
    my_d = my_q;
    if (ld_pair) begin
      mx_d = buf_q[rd_x];
      my_d = buf_q[rd_y];
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      mx_q    <= '0;
      my_q    <= '0;
`ifdef BLAKE2B_MSG_PRELOAD_EN
      bank_q  <= 1'b0;
      full_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      g_q     <= g_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
`ifdef BLAKE2B_MSG_PRELOAD_EN
      bank_q  <= bank_d;
      full_q  <= full_d;
`endif
    end
  end

  // Message store write; contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (beat && !rst_i) buf_q[wr_addr] <= msg_word_i;
  end

  assign g_valid_o  = vld_q;
  assign g_mx_o     = mx_q;
  assign g_my_o     = my_q;
  assign g_round_o  = r_q;
  assign g_index_o  = g_q;
  assign g_last_o   = last_q;
  assign blk_done_o = done_q;

endmodule
